// File: rtl/temp_abnormality_responder.sv
// rtl/temp_abnormality_responder.sv - debounced heater/cooler drive with latched alarm
// Optional eventCount output enabled by TEMP_EVENT_COUNTER_EN.
module temp_abnormality_responder #(
   parameter int DEBOUNCE = 3,
   parameter int MAX_ACT  = 15,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       lowTempAbnormality,
   input  logic       highTempAbnormality,
   input  logic       alarmAck,
   output logic       heaterOn,
   output logic       coolerOn,
   output logic       alarm,
   output logic [1:0] state
`ifdef TEMP_EVENT_COUNTER_EN
   ,
   output logic [7:0] eventCount
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HEAT  = 2'd1,
      COOL  = 2'd2,
      ALARM = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] DEB    = CNT_W'(DEBOUNCE);
   localparam logic [CNT_W-1:0] DEB_M1 = CNT_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_ACT - 1);

   state_t fsm;
   state_t nxt;

   logic [CNT_W-1:0] low_cnt;
   logic [CNT_W-1:0] high_cnt;
   logic [CNT_W-1:0] fault_cnt;
   logic [CNT_W-1:0] clear_cnt;
   logic [CNT_W-1:0] act_timer;

   logic q_low, q_high, q_fault, q_clear;
   logic fire_low, fire_high, fire_fault, fire_clear;
   logic active, timeout;

   assign q_low   =  lowTempAbnormality & ~highTempAbnormality;
   assign q_high  = ~lowTempAbnormality &  highTempAbnormality;
   assign q_fault =  lowTempAbnormality &  highTempAbnormality;
   assign q_clear = ~lowTempAbnormality & ~highTempAbnormality;

   // A saturated counter keeps firing, so a held flag still acts once enable returns.
   assign fire_low   = q_low   && (low_cnt   >= DEB_M1);
   assign fire_high  = q_high  && (high_cnt  >= DEB_M1);
   assign fire_fault = q_fault && (fault_cnt >= DEB_M1);
   assign fire_clear = q_clear && (clear_cnt >= DEB_M1);

   assign active  = (fsm == HEAT) || (fsm == COOL);
   assign timeout = active && (act_timer >= MAX_M1);

   assign state = fsm;

   function automatic logic [CNT_W-1:0] bump(input logic q, input logic [CNT_W-1:0] c);
      if (!q) return '0;
      if (c >= DEB) return DEB;
      return c + CNT_W'(1);
   endfunction

   always_comb begin
      nxt = fsm;
      unique case (fsm)
         IDLE: begin
            if (fire_fault)                nxt = ALARM;
            else if (enable && fire_low)   nxt = HEAT;
            else if (enable && fire_high)  nxt = COOL;
         end
         HEAT: begin
            if (fire_fault)                nxt = ALARM;
            else if (timeout)              nxt = ALARM;
            else if (!enable)              nxt = IDLE;
            else if (fire_high)            nxt = COOL;
            else if (fire_clear)           nxt = IDLE;
         end
         COOL: begin
            if (fire_fault)                nxt = ALARM;
            else if (timeout)              nxt = ALARM;
            else if (!enable)              nxt = IDLE;
            else if (fire_low)             nxt = HEAT;
            else if (fire_clear)           nxt = IDLE;
         end
         ALARM: begin
            if (alarmAck && q_clear)       nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm        <= IDLE;
         heaterOn   <= 1'b0;
         coolerOn   <= 1'b0;
         alarm      <= 1'b0;
         low_cnt    <= '0;
         high_cnt   <= '0;
         fault_cnt  <= '0;
         clear_cnt  <= '0;
         act_timer  <= '0;
`ifdef TEMP_EVENT_COUNTER_EN
         eventCount <= 8'd0;
`endif
      end else begin
         fsm      <= nxt;
         heaterOn <= (nxt == HEAT);
         coolerOn <= (nxt == COOL);
         alarm    <= (nxt == ALARM);
         if (nxt != fsm) begin
            low_cnt   <= '0;
            high_cnt  <= '0;
            fault_cnt <= '0;
            clear_cnt <= '0;
            act_timer <= '0;
         end else begin
            low_cnt   <= bump(q_low,   low_cnt);
            high_cnt  <= bump(q_high,  high_cnt);
            fault_cnt <= bump(q_fault, fault_cnt);
            clear_cnt <= bump(q_clear, clear_cnt);
            act_timer <= active ? act_timer + CNT_W'(1) : '0;
         end
`ifdef TEMP_EVENT_COUNTER_EN
         if ((nxt != fsm) && (nxt != IDLE) && (eventCount != 8'hFF))
            eventCount <= eventCount + 8'd1;
`endif
      end
   end

endmodule

// File: tb/tb_temp_abnormality_responder.sv
// tb/tb_temp_abnormality_responder.sv - directed and random bench with a cycle-level reference model
// Event counter checks are active when TEMP_EVENT_COUNTER_EN is defined.
module tb_temp_abnormality_responder;
   localparam int D = 3;
   localparam int M = 15;

   logic       clk = 1'b0;
   logic       reset, enable, low, high, ack;
   logic       heaterOn, coolerOn, alarm;
   logic [1:0] state;
`ifdef TEMP_EVENT_COUNTER_EN
   logic [7:0] eventCount;
`endif

   always #5 clk = ~clk;

   temp_abnormality_responder #(.DEBOUNCE(D), .MAX_ACT(M), .CNT_W(4)) dut (
      .clk                 (clk),
      .reset               (reset),
      .enable              (enable),
      .lowTempAbnormality  (low),
      .highTempAbnormality (high),
      .alarmAck            (ack),
      .heaterOn            (heaterOn),
      .coolerOn            (coolerOn),
      .alarm               (alarm),
      .state               (state)
`ifdef TEMP_EVENT_COUNTER_EN
      ,
      .eventCount          (eventCount)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: unbounded run lengths per qualifier and cycles spent in the current state.
   int m_state, r_low, r_high, r_fault, r_clear, elapsed, m_ev;

   task automatic model_step(input bit rs, input bit en, input bit lo, input bit hi, input bit ak);
      int nl, nh, nf, nc, ns;
      bit act;
      if (rs) begin
         m_state = 0; r_low = 0; r_high = 0; r_fault = 0; r_clear = 0; elapsed = 0; m_ev = 0;
      end else begin
         nl = (lo && !hi) ? r_low + 1 : 0;
         nh = (hi && !lo) ? r_high + 1 : 0;
         nf = (lo && hi) ? r_fault + 1 : 0;
         nc = (!lo && !hi) ? r_clear + 1 : 0;
         act = (m_state == 1) || (m_state == 2);
         ns = m_state;
         if (nf >= D && m_state != 3) ns = 3;
         else if (act && elapsed + 1 >= M) ns = 3;
         else if (m_state == 0) begin
            if (en && nl >= D) ns = 1;
            else if (en && nh >= D) ns = 2;
         end
         else if (act && !en) ns = 0;
         else if (m_state == 1 && nh >= D) ns = 2;
         else if (m_state == 2 && nl >= D) ns = 1;
         else if (act && nc >= D) ns = 0;
         else if (m_state == 3 && ak && !lo && !hi) ns = 0;
         if (ns != m_state) begin
            r_low = 0; r_high = 0; r_fault = 0; r_clear = 0; elapsed = 0;
            if (ns != 0 && m_ev < 255) m_ev++;
         end else begin
            r_low = nl; r_high = nh; r_fault = nf; r_clear = nc;
            elapsed = act ? elapsed + 1 : 0;
         end
         m_state = ns;
      end
   endtask

   task automatic cyc(input bit rs, input bit en, input bit lo, input bit hi, input bit ak);
      reset = rs; enable = en; low = lo; high = hi; ack = ak;
      @(posedge clk);
      model_step(rs, en, lo, hi, ak);
      #1;
      check("state", state, m_state);
      check("heaterOn", heaterOn, m_state == 1);
      check("coolerOn", coolerOn, m_state == 2);
      check("alarm", alarm, m_state == 3);
      check("invariant", (heaterOn & coolerOn) | (alarm & (heaterOn | coolerOn)), 0);
`ifdef TEMP_EVENT_COUNTER_EN
      check("eventCount", eventCount, m_ev);
`endif
   endtask

   initial begin
      int pat, len;
      bit en, rs;
      m_state = 0; r_low = 0; r_high = 0; r_fault = 0; r_clear = 0; elapsed = 0; m_ev = 0;

      // Reset state
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      check("s1_state", state, 0);
      check("s1_outs", {heaterOn, coolerOn, alarm}, 0);

      // Short low pulse is filtered, held low heats, drop returns to IDLE after debounce
      cyc(0, 1, 1, 0, 0);
      cyc(0, 1, 1, 0, 0);
      cyc(0, 1, 0, 0, 0);
      check("s2_short_pulse", state, 0);
      cyc(0, 1, 1, 0, 0);
      cyc(0, 1, 1, 0, 0);
      check("s2_before_heat", heaterOn, 0);
      cyc(0, 1, 1, 0, 0);
      check("s2_heat", heaterOn, 1);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      check("s2_still_heat", heaterOn, 1);
      cyc(0, 1, 0, 0, 0);
      check("s2_heat_off", heaterOn, 0);
      check("s2_idle", state, 0);

      // Cooling timeout escalates to alarm; ack only honoured with flags clear
      cyc(1, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, 0);
      check("s3_cool", coolerOn, 1);
      for (int i = 0; i < 14; i++) cyc(0, 1, 0, 1, 0);
      check("s3_pre_timeout", state, 2);
      cyc(0, 1, 0, 1, 0);
      check("s3_alarm", {alarm, coolerOn}, 2'b10);
      check("s3_alarm_state", state, 3);
      cyc(0, 1, 0, 1, 1);
      check("s3_ack_ignored", state, 3);
      cyc(0, 1, 0, 0, 1);
      check("s3_ack_exit", state, 0);

      // Sensor fault with enable low still alarms
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0);
      check("s4_fault_alarm", alarm, 1);
      check("s4_fault_state", state, 3);

      // Overshoot HEAT->COOL, enable drop, reset mid-HEAT
      cyc(1, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0);
      check("s5_heat", state, 1);
      cyc(0, 1, 0, 1, 0);
      cyc(0, 1, 0, 1, 0);
      check("s5_pre_overshoot", state, 1);
      cyc(0, 1, 0, 1, 0);
      check("s5_overshoot", {state, heaterOn, coolerOn}, {2'd2, 1'b0, 1'b1});
      cyc(0, 0, 0, 1, 0);
      check("s5_disable", {state, coolerOn}, {2'd0, 1'b0});
      for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0);
      check("s5_reheat", state, 1);
      cyc(1, 1, 1, 0, 0);
      check("s5_reset_heat", {state, heaterOn}, 3'd0);

`ifdef TEMP_EVENT_COUNTER_EN
      cyc(1, 1, 0, 0, 0);
      for (int k = 0; k < 300; k++) begin
         for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0);
         for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
      end
      check("s6_event_sat", eventCount, 255);
`endif

      // Randomized runs of held flag patterns
      cyc(1, 1, 0, 0, 0);
      for (int k = 0; k < 600; k++) begin
         pat = $urandom_range(0, 9);
         len = $urandom_range(1, 6);
         en  = ($urandom_range(0, 9) != 0);
         for (int i = 0; i < len; i++) begin
            rs = ($urandom_range(0, 149) == 0);
            cyc(rs, en, (pat <= 2) || (pat == 6), (pat >= 3 && pat <= 6),
                bit'($urandom_range(0, 1)));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
